// File: rtl/gmii_axis_rx_pkg.sv
// Shared Ethernet receive constants and the receiver state type.
package gmii_axis_rx_pkg;

  localparam logic [7:0]  ETH_PRE       = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  // Register value after running the reflected CRC over data plus a correct FCS.
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Bytes held back so the 4 FCS bytes never reach the stream.
  localparam int unsigned DL_DEPTH = 5;

  typedef enum logic [1:0] {
    StIdle,
    StPayload,
    StWaitEnd
  } rx_state_e;

endpackage

// File: rtl/gmii_axis_rx_lfsr.sv
// Galois-form LFSR / CRC step: advances the state by DATA_WIDTH input bits in one cycle.
// REVERSE=1 processes data LSB first with a bit-reflected polynomial (Ethernet CRC-32).
module gmii_axis_rx_lfsr #(
  parameter int unsigned           LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY  = 32'h04C11DB7,
  parameter bit                    REVERSE    = 1'b1,
  parameter int unsigned           DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [LFSR_WIDTH-1:0] state_in,
  output logic [LFSR_WIDTH-1:0] state_out
);

  function automatic logic [LFSR_WIDTH-1:0] reflect(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    for (int i = 0; i < int'(LFSR_WIDTH); i++) begin
      r[i] = v[LFSR_WIDTH-1-i];
    end
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] PolyRefl = reflect(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] st;
  logic                  fb;

  // Unrolled bit-serial shift over all data bits.
  always_comb begin
    st = state_in;
    fb = 1'b0;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      if (REVERSE) begin
        fb = st[0] ^ data_in[i];
        st = (st >> 1) ^ (fb ? PolyRefl : '0);
      end else begin
        fb = st[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
        st = (st << 1) ^ (fb ? LFSR_POLY : '0);
      end
    end
    state_out = st;
  end

endmodule

// File: rtl/gmii_axis_rx.sv
// GMII/MII frame receiver: finds the SFD, assembles MII nibbles, strips preamble and FCS,
// checks CRC-32 and emits the payload on an 8-bit AXI-Stream master (no backpressure).
// Outputs are the Mealy outputs of the byte consumed at the next enabled edge, so they
// are only asserted while clk_enable is high.
module gmii_axis_rx
  import gmii_axis_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] gmii_rxd,
  input  logic                  gmii_rx_dv,
  input  logic                  gmii_rx_er,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  input  logic                  clk_enable,
  input  logic                  mii_select,
  output logic                  start_packet,
  output logic                  error_bad_frame,
  output logic                  error_bad_fcs
);

  if (DATA_WIDTH != 8) begin : g_width_check
    always_ff @(posedge clk) $error("gmii_axis_rx: DATA_WIDTH must be 8");
  end

  localparam logic [2:0] DlFull = 3'(DL_DEPTH);

  rx_state_e state_q, state_d;

  // Sample stage: one assembled byte (or end-of-frame marker) per smp_vld_q.
  logic [DATA_WIDTH-1:0] smp_data_q, smp_data_d;
  logic                  smp_vld_q, smp_vld_d;
  logic                  smp_dv_q, smp_dv_d;
  logic                  smp_er_q, smp_er_d;

  // MII nibble assembly.
  logic [DATA_WIDTH-1:0] nib_byte_q, nib_byte_d;
  logic                  nib_dv_q, nib_dv_d;
  logic                  nib_er_q, nib_er_d;
  logic                  phase_q, phase_d;

  // Frame datapath; dl_q[0] is the newest byte.
  logic [DL_DEPTH-1:0][DATA_WIDTH-1:0] dl_q, dl_d;
  logic [2:0]                          count_q, count_d;
  logic                                err_q, err_d;
  logic [31:0]                         crc_q, crc_d, crc_next;

  logic beat, last, user, sop, bad_fcs, bad_frame, fcs_mismatch, active;

  gmii_axis_rx_lfsr #(
    .LFSR_WIDTH(32),
    .LFSR_POLY (CRC32_POLY),
    .REVERSE   (1'b1),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_crc (
    .data_in  (smp_data_q),
    .state_in (crc_q),
    .state_out(crc_next)
  );

  // Frame FSM: consume the registered sample, update delay line/CRC, decide outputs.
  always_comb begin
    state_d      = state_q;
    dl_d         = dl_q;
    count_d      = count_q;
    err_d        = err_q;
    crc_d        = crc_q;
    beat         = 1'b0;
    last         = 1'b0;
    user         = 1'b0;
    sop          = 1'b0;
    bad_fcs      = 1'b0;
    bad_frame    = 1'b0;
    fcs_mismatch = (crc_q != CRC32_RESIDUE);
    if (smp_vld_q) begin
      unique case (state_q)
        StIdle: begin
          if (smp_dv_q) begin
            if (smp_data_q == ETH_SFD) begin
              state_d = StPayload;
              crc_d   = '1;
              count_d = '0;
              err_d   = 1'b0;
              sop     = 1'b1;
            end else if (smp_data_q != ETH_PRE) begin
              state_d = StWaitEnd;
            end
          end
        end
        StPayload: begin
          if (smp_dv_q) begin
            dl_d  = {dl_q[DL_DEPTH-2:0], smp_data_q};
            crc_d = crc_next;
            err_d = err_q | smp_er_q;
            if (count_q == DlFull) begin
              beat = 1'b1;
            end else begin
              count_d = count_q + 3'd1;
            end
          end else begin
            state_d = StIdle;
            if (count_q == DlFull) begin
              beat      = 1'b1;
              last      = 1'b1;
              user      = err_q | fcs_mismatch;
              bad_fcs   = fcs_mismatch;
              bad_frame = err_q | fcs_mismatch;
            end else begin
              bad_frame = 1'b1;  // runt: nothing was ever emitted
            end
          end
        end
        StWaitEnd: begin
          if (!smp_dv_q) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Byte assembly: GMII passes through; MII pairs nibbles, realigning on every nibble
  // outside a frame so the SFD can land on either phase.
  always_comb begin
    nib_byte_d = nib_byte_q;
    nib_dv_d   = nib_dv_q;
    nib_er_d   = nib_er_q;
    phase_d    = 1'b0;
    smp_vld_d  = 1'b0;
    smp_data_d = smp_data_q;
    smp_dv_d   = 1'b0;
    smp_er_d   = 1'b0;
    if (!mii_select) begin
      smp_vld_d  = 1'b1;
      smp_data_d = gmii_rxd;
      smp_dv_d   = gmii_rx_dv;
      smp_er_d   = gmii_rx_er;
    end else begin
      nib_byte_d = {gmii_rxd[3:0], nib_byte_q[DATA_WIDTH-1:4]};
      nib_dv_d   = gmii_rx_dv;
      nib_er_d   = gmii_rx_er;
      smp_data_d = nib_byte_d;
      if (state_d != StPayload) begin
        smp_vld_d = 1'b1;
        smp_dv_d  = gmii_rx_dv & nib_dv_q;
        smp_er_d  = gmii_rx_er | nib_er_q;
      end else if (!phase_q) begin
        if (gmii_rx_dv) begin
          phase_d = 1'b1;
        end else begin
          smp_vld_d = 1'b1;  // dv dropped on the low nibble: end frame now
        end
      end else begin
        smp_vld_d = 1'b1;
        smp_dv_d  = gmii_rx_dv;
        smp_er_d  = gmii_rx_er | nib_er_q;
      end
    end
  end

  // Sample-stage registers, advanced only on enabled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      smp_data_q <= '0;
      smp_vld_q  <= 1'b0;
      smp_dv_q   <= 1'b0;
      smp_er_q   <= 1'b0;
      nib_byte_q <= '0;
      nib_dv_q   <= 1'b0;
      nib_er_q   <= 1'b0;
      phase_q    <= 1'b0;
    end else if (clk_enable) begin
      smp_data_q <= smp_data_d;
      smp_vld_q  <= smp_vld_d;
      smp_dv_q   <= smp_dv_d;
      smp_er_q   <= smp_er_d;
      nib_byte_q <= nib_byte_d;
      nib_dv_q   <= nib_dv_d;
      nib_er_q   <= nib_er_d;
      phase_q    <= phase_d;
    end
  end

  // Frame-state registers, advanced only on enabled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      dl_q    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      crc_q   <= '1;
    end else if (clk_enable) begin
      state_q <= state_d;
      dl_q    <= dl_d;
      count_q <= count_d;
      err_q   <= err_d;
      crc_q   <= crc_d;
    end
  end

  // Outputs only exist on enabled, out-of-reset cycles.
  always_comb begin
    active          = clk_enable & rst_n;
    m_axis_tvalid   = active & beat;
    m_axis_tlast    = active & last;
    m_axis_tuser    = active & user;
    m_axis_tdata    = (active & beat) ? dl_q[DL_DEPTH-1] : '0;
    start_packet    = active & sop;
    error_bad_fcs   = active & bad_fcs;
    error_bad_frame = active & bad_frame;
  end

endmodule

// File: tb/tb_gmii_axis_rx.sv
// Self-checking bench for gmii_axis_rx: table-driven frames, hand-written corner sequences
// and random frames scored against a frame-level reference model.
module tb_gmii_axis_rx;

  typedef byte unsigned bq_t[$];

  typedef struct {
    bit mii;
    int per;
    int pre;
    int len;
    bit flip;
    int er;
    int beats;
    bit user;
    bit fcs;
    bit bf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] gmii_rxd = '0;
  logic       gmii_rx_dv = 1'b0;
  logic       gmii_rx_er = 1'b0;
  logic       clk_enable = 1'b0;
  logic       mii_select = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid, m_axis_tlast, m_axis_tuser;
  logic       start_packet, error_bad_frame, error_bad_fcs;

  always #5 clk = ~clk;

  gmii_axis_rx #(
    .DATA_WIDTH(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .gmii_rxd       (gmii_rxd),
    .gmii_rx_dv     (gmii_rx_dv),
    .gmii_rx_er     (gmii_rx_er),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .clk_enable     (clk_enable),
    .mii_select     (mii_select),
    .start_packet   (start_packet),
    .error_bad_frame(error_bad_frame),
    .error_bad_fcs  (error_bad_fcs)
  );

  int checks = 0;
  int passes = 0;
  int period = 1;

  // Observed (monitor-owned).
  byte unsigned got_data[$];
  int           got_last_pos[$];
  bit           got_user[$];
  int           got_sp = 0, got_bf = 0, got_fcs = 0, got_off = 0;

  // Expected per group and group base indices.
  byte unsigned exp_data[$];
  int           exp_last_pos[$];
  bit           exp_user[$];
  int           exp_sp, exp_bf, exp_fcs;
  int           b_data, b_last, b_sp, b_bf, b_fcs, b_off;

  // Sample outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (!clk_enable && (m_axis_tvalid || m_axis_tlast || m_axis_tuser || start_packet ||
                        error_bad_frame || error_bad_fcs)) got_off++;
    if (m_axis_tvalid) begin
      got_data.push_back(m_axis_tdata);
      if (m_axis_tlast) begin
        got_last_pos.push_back(got_data.size() - 1);
        got_user.push_back(m_axis_tuser);
      end
    end else if (m_axis_tlast || m_axis_tuser) begin
      got_off++;
    end
    if (start_packet) got_sp++;
    if (error_bad_frame) got_bf++;
    if (error_bad_fcs) got_fcs++;
  end

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  function automatic logic [31:0] crc32(input bq_t q, input int n);
    logic [31:0] c;
    c = '1;
    for (int i = 0; i < n; i++) begin
      c ^= {24'h0, q[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bq_t with_fcs(input bq_t p);
    bq_t         q;
    logic [31:0] c;
    q = p;
    c = crc32(p, p.size());
    for (int i = 0; i < 4; i++) q.push_back(c[8*i +: 8]);
    return q;
  endfunction

  // One enabled sample, preceded by period-1 disabled cycles carrying garbage.
  task automatic put(input logic [7:0] d, input logic dv, input logic er);
    for (int i = 1; i < period; i++) begin
      clk_enable = 1'b0;
      gmii_rxd   = 8'($urandom);
      gmii_rx_dv = 1'($urandom);
      gmii_rx_er = 1'($urandom);
      @(posedge clk);
      #1;
    end
    clk_enable = 1'b1;
    gmii_rxd   = d;
    gmii_rx_dv = dv;
    gmii_rx_er = er;
    @(posedge clk);
    #1;
  endtask

  task automatic put_byte(input logic [7:0] b, input logic dv, input logic er);
    if (mii_select) begin
      put({4'($urandom), b[3:0]}, dv, er);
      put({4'($urandom), b[7:4]}, dv, er);
    end else begin
      put(b, dv, er);
    end
  endtask

  task automatic send_frame(input bit mii, input int per, input int pre, input bq_t bytes,
                            input int er_idx, input int ifg);
    mii_select = mii;
    period     = per;
    repeat (pre) put_byte(8'h55, 1'b1, 1'b0);
    put_byte(8'hD5, 1'b1, 1'b0);
    foreach (bytes[i]) put_byte(bytes[i], 1'b1, i == er_idx);
    repeat (ifg) put_byte(8'h00, 1'b0, 1'b0);
  endtask

  // Reference model: what one frame (post-SFD bytes incl. FCS) must produce.
  task automatic model_expect(input bq_t bytes, input int er_idx);
    int          t;
    bit          fcs_ok, usr;
    logic [31:0] rx_fcs;
    t = bytes.size();
    exp_sp++;
    if (t < 5) begin
      exp_bf++;
    end else begin
      rx_fcs = {bytes[t-1], bytes[t-2], bytes[t-3], bytes[t-4]};
      fcs_ok = (crc32(bytes, t - 4) == rx_fcs);
      usr    = (er_idx >= 0 && er_idx < t) || !fcs_ok;
      for (int i = 0; i < t - 4; i++) exp_data.push_back(bytes[i]);
      exp_last_pos.push_back(exp_data.size() - 1);
      exp_user.push_back(usr);
      if (!fcs_ok) exp_fcs++;
      if (usr) exp_bf++;
    end
  endtask

  task automatic begin_group();
    exp_data.delete();
    exp_last_pos.delete();
    exp_user.delete();
    exp_sp = 0;
    exp_bf = 0;
    exp_fcs = 0;
    b_data = got_data.size();
    b_last = got_last_pos.size();
    b_sp = got_sp;
    b_bf = got_bf;
    b_fcs = got_fcs;
    b_off = got_off;
  endtask

  task automatic check_group(input string name);
    int n, nl;
    repeat (3) put(8'h00, 1'b0, 1'b0);
    n  = got_data.size() - b_data;
    nl = got_last_pos.size() - b_last;
    chk({name, " beats"}, n, exp_data.size());
    for (int i = 0; i < n && i < exp_data.size(); i++)
      chk($sformatf("%s data[%0d]", name, i), got_data[b_data+i], exp_data[i]);
    chk({name, " tlast count"}, nl, exp_last_pos.size());
    for (int i = 0; i < nl && i < exp_last_pos.size(); i++) begin
      chk($sformatf("%s tlast pos[%0d]", name, i), got_last_pos[b_last+i] - b_data,
          exp_last_pos[i]);
      chk($sformatf("%s tuser[%0d]", name, i), got_user[b_last+i], exp_user[i]);
    end
    chk({name, " start_packet"}, got_sp - b_sp, exp_sp);
    chk({name, " error_bad_frame"}, got_bf - b_bf, exp_bf);
    chk({name, " error_bad_fcs"}, got_fcs - b_fcs, exp_fcs);
    chk({name, " outputs on disabled cycles"}, got_off - b_off, 0);
  endtask

  vec_t vecs[6];

  initial begin
    bq_t pay, frm;
    int  n;
    bit  pref_ok;

    vecs[0] = '{0, 1, 7, 60, 0, -1, 60, 0, 0, 0};  // good GMII frame
    vecs[1] = '{0, 1, 7, 60, 1, -1, 60, 1, 1, 1};  // corrupted FCS
    vecs[2] = '{0, 1, 7, 60, 0, 10, 60, 1, 0, 1};  // rx_er on byte 10
    vecs[3] = '{1, 10, 2, 46, 0, -1, 46, 0, 0, 0}; // MII, 1-of-10 enable
    vecs[4] = '{0, 1, 0, 1, 0, -1, 1, 0, 0, 0};    // no preamble, 1-byte payload
    vecs[5] = '{1, 1, 7, 64, 1, -1, 64, 1, 1, 1};  // MII, bad FCS

    // Reset state.
    clk_enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset tvalid", m_axis_tvalid, 0);
    chk("reset tlast", m_axis_tlast, 0);
    chk("reset tuser", m_axis_tuser, 0);
    chk("reset tdata", m_axis_tdata, 0);
    chk("reset start_packet", start_packet, 0);
    chk("reset error_bad_frame", error_bad_frame, 0);
    chk("reset error_bad_fcs", error_bad_fcs, 0);
    @(posedge clk);
    #1;

    // Table-driven frames.
    foreach (vecs[v]) begin
      begin_group();
      pay.delete();
      for (int i = 0; i < vecs[v].len; i++) pay.push_back(8'(i));
      frm = with_fcs(pay);
      if (vecs[v].flip) frm[frm.size()-2] ^= 8'h01;
      exp_sp = 1;
      for (int i = 0; i < vecs[v].beats; i++) exp_data.push_back(8'(i));
      exp_last_pos.push_back(vecs[v].beats - 1);
      exp_user.push_back(vecs[v].user);
      exp_fcs = int'(vecs[v].fcs);
      exp_bf  = int'(vecs[v].bf);
      send_frame(vecs[v].mii, vecs[v].per, vecs[v].pre, frm, vecs[v].er, 2);
      check_group($sformatf("vec%0d", v));
    end

    // Runt followed by a zero-IFG frame.
    begin_group();
    frm = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
    model_expect(frm, -1);
    send_frame(0, 1, 3, frm, -1, 1);
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(8'(8'h80 + i));
    frm = with_fcs(pay);
    model_expect(frm, -1);
    send_frame(0, 1, 0, frm, -1, 2);
    check_group("runt+b2b");

    // Reset pulse at payload byte 20: partial output, never a tlast.
    begin_group();
    pay.delete();
    for (int i = 0; i < 60; i++) pay.push_back(8'(i));
    frm = with_fcs(pay);
    mii_select = 1'b0;
    period = 1;
    repeat (7) put(8'h55, 1'b1, 1'b0);
    put(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) put(frm[i], 1'b1, 1'b0);
    rst_n = 1'b0;
    put(frm[20], 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 21; i < frm.size(); i++) put(frm[i], 1'b1, 1'b0);
    repeat (5) put(8'h00, 1'b0, 1'b0);
    n = got_data.size() - b_data;
    pref_ok = 1'b1;
    for (int i = 0; i < n; i++) if (got_data[b_data+i] != 8'(i)) pref_ok = 1'b0;
    chk("reset-mid beats in 14..15", (n >= 14 && n <= 15), 1);
    chk("reset-mid beats are payload prefix", pref_ok, 1);
    chk("reset-mid tlast count", got_last_pos.size() - b_last, 0);
    chk("reset-mid error_bad_frame", got_bf - b_bf, 0);
    chk("reset-mid error_bad_fcs", got_fcs - b_fcs, 0);
    begin_group();
    pay.delete();
    for (int i = 0; i < 30; i++) pay.push_back(8'($urandom));
    frm = with_fcs(pay);
    model_expect(frm, -1);
    send_frame(0, 1, 7, frm, -1, 2);
    check_group("after-reset");

    // Random frames against the reference model.
    for (int r = 0; r < 8; r++) begin
      bit mii;
      int per, pre, len, er;
      begin_group();
      mii = 1'($urandom);
      per = $urandom_range(1, 3);
      pre = $urandom_range(0, 7);
      len = $urandom_range(1, 40);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
      frm = with_fcs(pay);
      if ($urandom_range(0, 3) == 0) frm[$urandom_range(0, frm.size() - 1)] ^= 8'h10;
      er = ($urandom_range(0, 3) == 0) ? $urandom_range(0, frm.size() - 1) : -1;
      model_expect(frm, er);
      send_frame(mii, per, pre, frm, er, 2);
      check_group($sformatf("rand%0d", r));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
